// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one fixed-latency synchronous memory between
// instruction fetch (IF) and data access (DM), with DM priority and IF anti-starvation.
module mem_arbiter #(
   parameter int AW         = 16,
   parameter int DW         = 16,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_ack,
   output logic          stall_if,
   output logic          stall_mem,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int CW = $clog2(MEM_LAT + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] LAT_LOAD   = CW'(MEM_LAT);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t          state_reg;
   logic [CW-1:0]   cnt_reg;
   logic [SW-1:0]   starve_reg;
   logic            owner_reg;       // 0 = IF, 1 = DM
   logic            txn_we_reg;
   logic            mem_en_reg;
   logic            mem_we_reg;
   logic [AW-1:0]   mem_addr_reg;
   logic [DW-1:0]   mem_wdata_reg;
   logic [1:0]      ack_reg;         // index 0 = IF, 1 = DM
   logic [1:0]      req_live;
   logic            if_wins;
   logic            capture;
   logic [DW-1:0]   rdata_bus [2];

   // A requester whose ack is high this cycle is invisible to arbitration.
   assign req_live = {dm_req & ~ack_reg[1], if_req & ~ack_reg[0]};
   assign if_wins  = req_live[0] & (~req_live[1] | (starve_reg == STARVE_TOP));
   assign capture  = (state_reg == WAIT) && (cnt_reg == CW'(1)) && !txn_we_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         starve_reg    <= '0;
         owner_reg     <= 1'b0;
         txn_we_reg    <= 1'b0;
         mem_en_reg    <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         ack_reg       <= '0;
      end else begin
         mem_en_reg <= 1'b0;
         mem_we_reg <= 1'b0;
         ack_reg    <= '0;
         case (state_reg)
            IDLE: begin
               if (req_live != 2'b00) begin
                  mem_en_reg <= 1'b1;
                  state_reg  <= ISSUE;
                  if (if_wins) begin
                     owner_reg     <= 1'b0;
                     txn_we_reg    <= 1'b0;
                     mem_addr_reg  <= if_addr;
                     mem_wdata_reg <= '0;
                     starve_reg    <= '0;
                  end else begin
                     owner_reg     <= 1'b1;
                     txn_we_reg    <= dm_we;
                     mem_we_reg    <= dm_we;
                     mem_addr_reg  <= dm_addr;
                     mem_wdata_reg <= dm_wdata;
                     if (req_live[0] && (starve_reg != STARVE_TOP))
                        starve_reg <= starve_reg + SW'(1);
                  end
               end
            end
            ISSUE: begin
               cnt_reg   <= LAT_LOAD;
               state_reg <= WAIT;
            end
            WAIT: begin
               cnt_reg <= cnt_reg - CW'(1);
               if (cnt_reg == CW'(1)) begin
                  ack_reg[owner_reg] <= 1'b1;
                  state_reg          <= DONE;
               end
            end
            DONE: state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Per-owner read data; a write completion leaves the owner's value untouched.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rdata
         logic [DW-1:0] rdata_reg;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               rdata_reg <= '0;
            else if (capture && (owner_reg == 1'(gi)))
               rdata_reg <= mem_rdata;
         end
         assign rdata_bus[gi] = rdata_reg;
      end
   endgenerate

   assign if_rdata  = rdata_bus[0];
   assign dm_rdata  = rdata_bus[1];
   assign if_ack    = ack_reg[0];
   assign dm_ack    = ack_reg[1];
   assign stall_if  = if_req & ~ack_reg[0];
   assign stall_mem = dm_req & ~ack_reg[1];
   assign mem_en    = mem_en_reg;
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbitration and timing rules.
module tb_mem_arbiter;

   localparam int AW = 16, DW = 16, LAT = 2, SMAX = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, dm_req, dm_we;
   logic [AW-1:0] if_addr, dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] if_rdata, dm_rdata;
   logic          if_ack, dm_ack, stall_if, stall_mem;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Memory: data is valid only in the cycle ending LAT edges after the mem_en edge.
   logic [DW-1:0] pipe_d [LAT];
   logic          pipe_v [LAT];
   initial for (int i = 0; i < LAT; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = '0; end
   always @(posedge clk) begin
      pipe_v[0] <= mem_en;
      pipe_d[0] <= mem_addr ^ 16'hA5A5;
      for (int i = 1; i < LAT; i++) begin
         pipe_v[i] <= pipe_v[i-1];
         pipe_d[i] <= pipe_d[i-1];
      end
   end
   assign mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : 16'hDEAD;

   wire [69:0] obs = {mem_en, mem_we, mem_addr, mem_wdata, if_ack, dm_ack,
                      if_rdata, dm_rdata, stall_if, stall_mem};

   task automatic clear_inputs();
      if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Raises one request, watches 10 cycles, drops the request on its ack.
   task automatic run_txn(input bit dm, input logic [15:0] addr, input bit we, input logic [15:0] wd,
                          output int en_first, output int en_cnt, output int we_cnt, output int ack_cyc,
                          output logic [15:0] a_at_en, output logic [15:0] w_at_en,
                          output logic [15:0] rd_at_ack, output int stall_bad);
      bit done;
      logic st;
      en_first = -1; en_cnt = 0; we_cnt = 0; ack_cyc = -1; stall_bad = 0; done = 0;
      a_at_en = '0; w_at_en = '0; rd_at_ack = '0;
      if (dm) begin dm_req = 1; dm_addr = addr; dm_we = we; dm_wdata = wd; end
      else begin if_req = 1; if_addr = addr; end
      #1;
      for (int c = 0; c <= 10; c++) begin
         if (c > 0) @(negedge clk);
         if (mem_en) begin
            en_cnt++;
            if (en_first < 0) begin en_first = c; a_at_en = mem_addr; w_at_en = mem_wdata; end
         end
         if (mem_we) we_cnt++;
         st = dm ? stall_mem : stall_if;
         if ((dm ? dm_ack : if_ack) && !done) begin
            ack_cyc = c; rd_at_ack = dm ? dm_rdata : if_rdata; done = 1;
            if (st !== 1'b0) stall_bad++;
            if (dm) dm_req = 0; else if_req = 0;
         end else if (st !== logic'(!done)) stall_bad++;
      end
      if (dm) dm_req = 0; else if_req = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      n_cmp++; if (obs !== 70'h0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", obs); end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (obs !== 70'h0) begin n_bad++; $display("FAIL idle_after_reset: got %h want 0", obs); end
   endtask

   task automatic test_if_read();
      int ef, ec, wc, ac, sb; logic [15:0] a, w, rd;
      do_reset();
      run_txn(0, 16'h0010, 0, 16'h0, ef, ec, wc, ac, a, w, rd, sb);
      n_cmp++; if (ef !== 1) begin n_bad++; $display("FAIL if_en_cycle: got %0d want 1", ef); end
      n_cmp++; if (ec !== 1) begin n_bad++; $display("FAIL if_en_count: got %0d want 1", ec); end
      n_cmp++; if (ac !== 4) begin n_bad++; $display("FAIL if_ack_cycle: got %0d want 4", ac); end
      n_cmp++; if (a !== 16'h0010) begin n_bad++; $display("FAIL if_mem_addr: got %h want 0010", a); end
      n_cmp++; if (rd !== 16'hA5B5) begin n_bad++; $display("FAIL if_rdata: got %h want a5b5", rd); end
      n_cmp++; if (sb !== 0) begin n_bad++; $display("FAIL if_stall: got %0d bad cycles want 0", sb); end
      $display("txn if_read addr=0010 ack_cycle=%0d rdata=%h", ac, rd);
   endtask

   task automatic test_dm_write_read();
      int ef, ec, wc, ac, sb; logic [15:0] a, w, rd;
      do_reset();
      run_txn(1, 16'h0040, 1, 16'h1234, ef, ec, wc, ac, a, w, rd, sb);
      n_cmp++; if (wc !== 1 || ef !== 1) begin n_bad++; $display("FAIL wr_mem_we: got we_cnt=%0d en_cycle=%0d want 1/1", wc, ef); end
      n_cmp++; if (w !== 16'h1234 || a !== 16'h0040) begin n_bad++; $display("FAIL wr_fields: got %h@%h want 1234@0040", w, a); end
      n_cmp++; if (ac !== 4) begin n_bad++; $display("FAIL wr_ack_cycle: got %0d want 4", ac); end
      n_cmp++; if (rd !== 16'h0000) begin n_bad++; $display("FAIL wr_rdata_hold: got %h want 0000", rd); end
      $display("txn dm_write addr=0040 data=1234 ack_cycle=%0d dm_rdata=%h", ac, rd);
      run_txn(1, 16'h0040, 0, 16'h0, ef, ec, wc, ac, a, w, rd, sb);
      n_cmp++; if (wc !== 0) begin n_bad++; $display("FAIL rd_mem_we: got %0d want 0", wc); end
      n_cmp++; if (ac !== 4) begin n_bad++; $display("FAIL rd_ack_cycle: got %0d want 4", ac); end
      n_cmp++; if (rd !== 16'hA5E5) begin n_bad++; $display("FAIL rd_rdata: got %h want a5e5", rd); end
      n_cmp++; if (sb !== 0) begin n_bad++; $display("FAIL rd_stall: got %0d bad cycles want 0", sb); end
      $display("txn dm_read addr=0040 ack_cycle=%0d dm_rdata=%h", ac, rd);
   endtask

   task automatic test_simultaneous();
      int en_cnt = 0, dm_acks = 0, dm_c = -1, if_c = -1;
      logic [15:0] g0 = '0, g1 = '0, ird = '0;
      do_reset();
      if_req = 1; if_addr = 16'h0111;
      dm_req = 1; dm_addr = 16'h0222; dm_we = 0;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (mem_en) begin
            if (en_cnt == 0) g0 = mem_addr; else if (en_cnt == 1) g1 = mem_addr;
            en_cnt++;
         end
         if (dm_ack) begin dm_acks++; if (dm_c < 0) dm_c = c; dm_req = 0; end
         if (if_ack && if_c < 0) begin if_c = c; ird = if_rdata; if_req = 0; end
      end
      clear_inputs();
      n_cmp++; if (g0 !== 16'h0222 || g1 !== 16'h0111) begin n_bad++; $display("FAIL sim_order: got %h,%h want 0222,0111", g0, g1); end
      n_cmp++; if (dm_c !== 4) begin n_bad++; $display("FAIL sim_dm_ack: got %0d want 4", dm_c); end
      n_cmp++; if (if_c !== dm_c + 5) begin n_bad++; $display("FAIL sim_if_ack: got %0d want %0d", if_c, dm_c + 5); end
      n_cmp++; if (en_cnt !== 2 || dm_acks !== 1) begin n_bad++; $display("FAIL sim_grants: got en=%0d dm_acks=%0d want 2/1", en_cnt, dm_acks); end
      n_cmp++; if (ird !== (16'h0111 ^ 16'hA5A5)) begin n_bad++; $display("FAIL sim_if_rdata: got %h want %h", ird, 16'h0111 ^ 16'hA5A5); end
      $display("txn simultaneous dm_ack=%0d if_ack=%0d", dm_c, if_c);
   endtask

   task automatic test_starvation();
      bit exp_order [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
      bit order [8];
      int cyc [8];
      int n = 0, gap_bad = 0;
      do_reset();
      if_req = 1; if_addr = 16'h1000;
      dm_req = 1; dm_addr = 16'h2000; dm_we = 0;
      for (int c = 1; c <= 60 && n < 8; c++) begin
         @(negedge clk);
         if (dm_ack) begin order[n] = 1; cyc[n] = c; n++; dm_addr = dm_addr + 16'h1; end
         else if (if_ack) begin order[n] = 0; cyc[n] = c; n++; if_addr = if_addr + 16'h1; end
      end
      clear_inputs();
      n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL starve_count: got %0d acks want 8", n); end
      for (int k = 0; k < n; k++) begin
         n_cmp++;
         if (order[k] !== exp_order[k]) begin n_bad++; $display("FAIL starve_order[%0d]: got dm=%0d want dm=%0d", k, order[k], exp_order[k]); end
         if (k > 0 && cyc[k] - cyc[k-1] != LAT + 3) gap_bad++;
      end
      n_cmp++; if (gap_bad !== 0) begin n_bad++; $display("FAIL starve_spacing: got %0d bad gaps want 0", gap_bad); end
      $display("txn starvation acks=%0d gaps_bad=%0d", n, gap_bad);
   endtask

   task automatic test_hold();
      int hold_bad = 0, ac = -1;
      logic [15:0] rd = '0;
      do_reset();
      dm_req = 1; dm_addr = 16'h0080; dm_we = 0; dm_wdata = 16'h0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (mem_addr !== 16'h0080 || mem_we !== 1'b0) hold_bad++;
         if (c == 2) begin dm_addr = 16'hFFFF; dm_we = 1; dm_wdata = 16'hBEEF; #1; end
         if (dm_ack && ac < 0) begin ac = c; rd = dm_rdata; dm_req = 0; end
      end
      clear_inputs();
      n_cmp++; if (hold_bad !== 0) begin n_bad++; $display("FAIL hold_addr: got %0d bad cycles want 0", hold_bad); end
      n_cmp++; if (ac !== 4) begin n_bad++; $display("FAIL hold_ack: got %0d want 4", ac); end
      n_cmp++; if (rd !== 16'hA525) begin n_bad++; $display("FAIL hold_rdata: got %h want a525", rd); end
      $display("txn hold addr=0080 ack_cycle=%0d rdata=%h", ac, rd);
   endtask

   task automatic test_reset_mid_wait();
      int ef, ec, wc, ac, sb, stray = 0; logic [15:0] a, w, rd;
      do_reset();
      run_txn(0, 16'h0033, 0, 16'h0, ef, ec, wc, ac, a, w, rd, sb);
      run_txn(1, 16'h0044, 0, 16'h0, ef, ec, wc, ac, a, w, rd, sb);
      dm_req = 1; dm_addr = 16'h0055; dm_we = 0; dm_wdata = 16'h7777;
      repeat (2) @(negedge clk);
      rst = 1'b0; dm_req = 0;
      #1;
      n_cmp++; if (obs !== 70'h0) begin n_bad++; $display("FAIL midwait_reset: got %h want 0", obs); end
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (if_ack || dm_ack || mem_en) stray++;
      end
      n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL midwait_stray: got %0d cycles want 0", stray); end
      run_txn(1, 16'h0066, 0, 16'h0, ef, ec, wc, ac, a, w, rd, sb);
      n_cmp++; if (ac !== 4 || rd !== (16'h0066 ^ 16'hA5A5)) begin n_bad++; $display("FAIL midwait_reissue: got ack=%0d rdata=%h want 4/%h", ac, rd, 16'h0066 ^ 16'hA5A5); end
      $display("txn reset_mid_wait stray=%0d reissue_ack=%0d rdata=%h", stray, ac, rd);
   endtask

   // Randomized traffic; the model tracks cycles since grant and applies priority/starvation rules.
   task automatic test_random();
      int t = -1, m_st = 0, grants = 0, bad0;
      bit m_own = 0, m_we = 0, live0, live1;
      logic [15:0] m_addr = '0, m_wd = '0;
      logic [15:0] m_rd [2] = '{16'h0, 16'h0};
      bit [1:0] e_ack, p_ack = 2'b00;
      bit p_req [2] = '{0, 0};
      logic [15:0] p_addr [2] = '{16'h0, 16'h0};
      bit p_we = 0;
      logic [15:0] p_wd = '0;
      bit r_req [2] = '{0, 0};
      logic [69:0] exp;
      do_reset();
      bad0 = n_bad;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (t == -1 || t == LAT + 2) begin
            live0 = p_req[0] & ~p_ack[0];
            live1 = p_req[1] & ~p_ack[1];
            if (live0 || live1) begin
               if (live0 && (!live1 || m_st == SMAX)) begin
                  m_own = 0; m_addr = p_addr[0]; m_we = 0; m_wd = '0; m_st = 0;
               end else begin
                  m_own = 1; m_addr = p_addr[1]; m_we = p_we; m_wd = p_wd;
                  if (live0 && m_st < SMAX) m_st++;
               end
               t = 0; grants++;
            end else t = -1;
         end else t++;
         e_ack = 2'b00;
         if (t == LAT + 1) begin
            e_ack[m_own] = 1'b1;
            if (!m_we) m_rd[m_own] = m_addr ^ 16'hA5A5;
         end
         exp = {t == 0, (t == 0) && m_we, m_addr, m_wd, e_ack[0], e_ack[1], m_rd[0], m_rd[1],
                r_req[0] & ~e_ack[0], r_req[1] & ~e_ack[1]};
         n_cmp++;
         if (obs !== exp) begin n_bad++; $display("FAIL random_cycle%0d: got %h want %h", cyc, obs, exp); end
         for (int i = 0; i < 2; i++) begin
            if (r_req[i]) begin
               if (i == 0 ? if_ack : dm_ack) begin
                  if ($urandom_range(1, 0) == 1) begin
                     if (i == 0) if_addr = 16'($urandom);
                     else begin dm_addr = 16'($urandom); dm_we = ($urandom_range(2, 0) == 0); dm_wdata = 16'($urandom); end
                  end else r_req[i] = 0;
               end else if ($urandom_range(3, 0) == 0) begin
                  if (i == 0) if_addr = 16'($urandom);
                  else begin dm_addr = 16'($urandom); dm_we = ($urandom_range(2, 0) == 0); dm_wdata = 16'($urandom); end
               end
            end else if ($urandom_range(2, 0) == 0) begin
               r_req[i] = 1;
               if (i == 0) if_addr = 16'($urandom);
               else begin dm_addr = 16'($urandom); dm_we = ($urandom_range(2, 0) == 0); dm_wdata = 16'($urandom); end
            end
         end
         if_req = r_req[0]; dm_req = r_req[1];
         p_req = r_req; p_addr[0] = if_addr; p_addr[1] = dm_addr; p_we = dm_we; p_wd = dm_wdata;
         p_ack = e_ack;
      end
      clear_inputs();
      $display("txn random cycles=400 grants=%0d new_mismatches=%0d", grants, n_bad - bad0);
   endtask

   initial begin
      test_reset();
      test_if_read();
      test_dm_write_read();
      test_simultaneous();
      test_starvation();
      test_hold();
      test_reset_mid_wait();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
